// File: rtl/sync_down_counter_14to0.sv
// Loadable down counter: MAX, MAX-1, ..., 0, then wraps to MAX, with zero/borrow/wrap flags.
// Define DOWN_COUNTER_HOLD_AT_ZERO_EN to stop at zero instead of wrapping (one-shot countdown).
module sync_down_counter_14to0 #(
  parameter int WIDTH = 4,
  parameter int MAX   = 14
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Zero,
  output logic             Borrow,
  output logic             Wrapped
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             wrapped_reg;
  logic             wrapped_next;
  logic [WIDTH:0]   low_zero;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] q_dec;

  // JK-style decrement: bit i toggles when every lower bit is already 0.
  // low_zero[WIDTH] doubles as the all-zero detect for the whole count.
  assign low_zero[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
      assign low_zero[gi+1] = low_zero[gi] & ~q_reg[gi];
      assign toggle[gi]     = low_zero[gi];
    end
  endgenerate

  assign q_dec = q_reg ^ toggle;

  always_comb begin
    q_next       = q_reg;
    wrapped_next = 1'b0;
    if (Load) begin
      q_next = (D > MAX_VAL) ? MAX_VAL : D;
    end else if (En) begin
      if (low_zero[WIDTH]) begin
`ifdef DOWN_COUNTER_HOLD_AT_ZERO_EN
        q_next = q_reg;
`else
        q_next       = MAX_VAL;
        wrapped_next = 1'b1;
`endif
      end else begin
        q_next = q_dec;
      end
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      q_reg       <= MAX_VAL;
      wrapped_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign Q       = q_reg;
  assign Zero    = low_zero[WIDTH];
  assign Wrapped = wrapped_reg;

`ifdef DOWN_COUNTER_HOLD_AT_ZERO_EN
  assign Borrow = 1'b0;
`else
  // Only true in the cycle whose edge performs the 0 -> MAX wrap.
  assign Borrow = En & low_zero[WIDTH] & ~Load;
`endif

endmodule
